// File: rtl/ctrl_pkg.sv
// Shared control-word layout for the control pipeline.
// Bit indices, bubble value and stage field widths.
package ctrl_pkg;

  localparam int CW = 8;

  localparam int RDST     = 7;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 5;
  localparam int ALUSRC   = 4;
  localparam int MRD      = 3;
  localparam int MWR      = 2;
  localparam int RWR      = 1;
  localparam int M2R      = 0;

  localparam logic [CW-1:0] CTRL_NOP = 8'b0;

  localparam int MEM_W = 4;
  localparam int WB_W  = 2;

  localparam logic [MEM_W-1:0] MEM_NOP = '0;
  localparam logic [WB_W-1:0]  WB_NOP  = '0;

  // Clears bits the control unit leaves undefined
  function automatic logic [CW-1:0] sanitize(
    input logic          v,
    input logic [CW-1:0] c
  );
    logic [CW-1:0] s;
    s      = c;
    s[RDST] = c[RDST] & c[RWR];
    s[M2R]  = c[M2R] & c[RWR];
    if (!v) s = CTRL_NOP;
    return s;
  endfunction

endpackage

// File: rtl/control_pipeline_hazard.sv
// Load-use detection and EX-stage redirect resolution.
// Purely combinational; flush wins over stall.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mrd,
  input  logic             ex_br,
  input  logic             ex_jp,
  input  logic             ex_zero,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic             id_rdst,
  input  logic             id_mwr,
  input  logic             id_br,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             stall,
  output logic             flush
);

  logic uses_rt;
  logic rs_hit;
  logic rt_hit;
  logic hazard;

  assign uses_rt = id_rdst | id_mwr | id_br;
  assign rs_hit  = (ex_rt == id_rs);
  assign rt_hit  = uses_rt & (ex_rt == id_rt);

  // $0 is never a real producer
  assign hazard = ex_mrd
                & (ex_rt != '0)
                & id_valid
                & (rs_hit | rt_hit);

  assign flush = ex_br & (ex_jp | ex_zero);
  assign stall = hazard & ~flush;

endmodule

// File: rtl/control_pipeline.sv
// ID/EX, EX/MEM and MEM/WB control registers
// with load-use stall and EX redirect bubbles.
module control_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IdValid,
  input  logic [CTRL_W-1:0] IdCtrl,
  input  logic              IdBranch,
  input  logic              IdJump,
  input  logic [REG_W-1:0]  IdRs,
  input  logic [REG_W-1:0]  IdRt,
  input  logic [REG_W-1:0]  IdRd,
  input  logic              ExZero,
  output logic              Stall,
  output logic              Flush,
  output logic [CTRL_W-1:0] ExCtrl,
  output logic              ExBranch,
  output logic              ExJump,
  output logic [REG_W-1:0]  ExRs,
  output logic [REG_W-1:0]  ExRt,
  output logic [REG_W-1:0]  ExRd,
  output logic [MEM_W-1:0]  MemCtrl,
  output logic [REG_W-1:0]  MemWriteReg,
  output logic [WB_W-1:0]   WbCtrl,
  output logic [REG_W-1:0]  WbWriteReg
);

  logic [CTRL_W-1:0] id_ctrl;
  logic              id_br;
  logic              id_jp;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic              id_bubble;
  logic [REG_W-1:0]  mem_wr_d;

  hazard_unit #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_mrd   (ExCtrl[MRD]),
    .ex_br    (ExBranch),
    .ex_jp    (ExJump),
    .ex_zero  (ExZero),
    .ex_rt    (ExRt),
    .id_valid (IdValid),
    .id_rdst  (IdCtrl[RDST]),
    .id_mwr   (IdCtrl[MWR]),
    .id_br    (IdBranch),
    .id_rs    (IdRs),
    .id_rt    (IdRt),
    .stall    (Stall),
    .flush    (Flush)
  );

  assign id_ctrl = sanitize(IdValid, IdCtrl);
  assign id_br   = IdValid & IdBranch;
  assign id_jp   = IdValid & IdJump;
  assign id_rs   = IdValid ? IdRs : '0;
  assign id_rt   = IdValid ? IdRt : '0;
  assign id_rd   = IdValid ? IdRd : '0;

  // Stall or Flush both mean ID must not enter EX
  assign id_bubble = Stall | Flush;

  always_ff @(posedge clk) begin
    if (rst || id_bubble) begin
      ExCtrl   <= CTRL_NOP;
      ExBranch <= 1'b0;
      ExJump   <= 1'b0;
      ExRs     <= '0;
      ExRt     <= '0;
      ExRd     <= '0;
    end else begin
      ExCtrl   <= id_ctrl;
      ExBranch <= id_br;
      ExJump   <= id_jp;
      ExRs     <= id_rs;
      ExRt     <= id_rt;
      ExRd     <= id_rd;
    end
  end

  always_comb begin
    mem_wr_d = '0;
    unique case (1'b1)
      ExCtrl[RWR] &  ExCtrl[RDST]: mem_wr_d = ExRd;
      ExCtrl[RWR] & ~ExCtrl[RDST]: mem_wr_d = ExRt;
      default:                     mem_wr_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MemCtrl     <= MEM_NOP;
      MemWriteReg <= '0;
    end else begin
      MemCtrl     <= ExCtrl[MEM_W-1:0];
      MemWriteReg <= mem_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WbCtrl     <= WB_NOP;
      WbWriteReg <= '0;
    end else begin
      WbCtrl     <= MemCtrl[WB_W-1:0];
      WbWriteReg <= MemWriteReg;
    end
  end

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline.
// Instruction-record reference model, negedge monitor.
module tb_control_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       IdValid;
  logic [7:0] IdCtrl;
  logic       IdBranch;
  logic       IdJump;
  logic [4:0] IdRs, IdRt, IdRd;
  logic       ExZero;
  logic       Stall, Flush;
  logic [7:0] ExCtrl;
  logic       ExBranch, ExJump;
  logic [4:0] ExRs, ExRt, ExRd;
  logic [3:0] MemCtrl;
  logic [4:0] MemWriteReg;
  logic [1:0] WbCtrl;
  logic [4:0] WbWriteReg;

  control_pipeline dut (
    .clk         (clk),
    .rst         (rst),
    .IdValid     (IdValid),
    .IdCtrl      (IdCtrl),
    .IdBranch    (IdBranch),
    .IdJump      (IdJump),
    .IdRs        (IdRs),
    .IdRt        (IdRt),
    .IdRd        (IdRd),
    .ExZero      (ExZero),
    .Stall       (Stall),
    .Flush       (Flush),
    .ExCtrl      (ExCtrl),
    .ExBranch    (ExBranch),
    .ExJump      (ExJump),
    .ExRs        (ExRs),
    .ExRt        (ExRt),
    .ExRd        (ExRd),
    .MemCtrl     (MemCtrl),
    .MemWriteReg (MemWriteReg),
    .WbCtrl      (WbCtrl),
    .WbWriteReg  (WbWriteReg)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] C_LW    = 8'b00011011;
  localparam logic [7:0] C_ADDU  = 8'b11000010;
  localparam logic [7:0] C_ADDIU = 8'b00010010;
  localparam logic [7:0] C_BEQ   = 8'b00100000;
  localparam logic [7:0] C_SW    = 8'b00010100;

  // One instruction as the spec describes it, field by field
  typedef struct packed {
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       jump;
    logic [4:0] rs, rt, rd;
  } ins_t;

  typedef struct packed {
    logic       stall;
    logic       flush;
    logic [7:0] exctrl;
    logic       exbr;
    logic       exjp;
    logic [4:0] exrs, exrt, exrd;
    logic [3:0] memctrl;
    logic [4:0] memwr;
    logic [1:0] wbctrl;
    logic [4:0] wbwr;
  } out_t;

  ins_t pipe_ex, pipe_mem, pipe_wb;
  out_t exp_q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int n_stall = 0;
  int n_flush = 0;
  int n_both  = 0;

  function automatic ins_t capture(
    input logic v, input logic [7:0] c,
    input logic br, input logic jp,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd
  );
    ins_t i;
    i = '0;
    if (v) begin
      i.regwrite = c[1];
      i.regdst   = c[7] && i.regwrite;
      i.memtoreg = c[0] && i.regwrite;
      i.aluop    = c[6:5];
      i.alusrc   = c[4];
      i.memread  = c[3];
      i.memwrite = c[2];
      i.branch   = br;
      i.jump     = jp;
      i.rs = rs;
      i.rt = rt;
      i.rd = rd;
    end
    return i;
  endfunction

  function automatic logic [4:0] dest(input ins_t i);
    if (!i.regwrite) return 5'd0;
    return i.regdst ? i.rd : i.rt;
  endfunction

  function automatic out_t predict(
    input logic v, input logic [7:0] c, input logic br,
    input logic [4:0] rs, input logic [4:0] rt, input logic z
  );
    out_t o;
    logic reads_rt, hz;
    reads_rt = c[7] || c[2] || br;
    hz = pipe_ex.memread && pipe_ex.rt != 0 && v &&
         (pipe_ex.rt == rs || (reads_rt && pipe_ex.rt == rt));
    o.flush   = pipe_ex.branch && (pipe_ex.jump || z);
    o.stall   = hz && !o.flush;
    o.exctrl  = {pipe_ex.regdst, pipe_ex.aluop, pipe_ex.alusrc,
                 pipe_ex.memread, pipe_ex.memwrite,
                 pipe_ex.regwrite, pipe_ex.memtoreg};
    o.exbr    = pipe_ex.branch;
    o.exjp    = pipe_ex.jump;
    o.exrs    = pipe_ex.rs;
    o.exrt    = pipe_ex.rt;
    o.exrd    = pipe_ex.rd;
    o.memctrl = {pipe_mem.memread, pipe_mem.memwrite,
                 pipe_mem.regwrite, pipe_mem.memtoreg};
    o.memwr   = dest(pipe_mem);
    o.wbctrl  = {pipe_wb.regwrite, pipe_wb.memtoreg};
    o.wbwr    = dest(pipe_wb);
    return o;
  endfunction

  // One clock: drive ID, queue expected view, advance the model
  task automatic cycle(
    input logic v, input logic [7:0] c, input logic br, input logic jp,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic z, input logic r, output logic st
  );
    out_t e;
    @(posedge clk);
    #1;
    rst = r; IdValid = v; IdCtrl = c; IdBranch = br; IdJump = jp;
    IdRs = rs; IdRt = rt; IdRd = rd; ExZero = z;
    e = predict(v, c, br, rs, rt, z);
    exp_q.push_back(e);
    st = e.stall;
    if (r) begin
      pipe_ex = '0; pipe_mem = '0; pipe_wb = '0;
    end else begin
      pipe_wb  = pipe_mem;
      pipe_mem = pipe_ex;
      pipe_ex  = (e.stall || e.flush) ? '0 :
                 capture(v, c, br, jp, rs, rt, rd);
    end
  endtask

  // Present an instruction, holding it while the pipeline stalls
  task automatic issue(
    input logic v, input logic [7:0] c, input logic br, input logic jp,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
    input logic z
  );
    logic st;
    for (int k = 0; k < 4; k++) begin
      cycle(v, c, br, jp, rs, rt, rd, z, 1'b0, st);
      if (!st) break;
    end
  endtask

  task automatic nop(input logic z);
    issue(1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, z);
  endtask

  always @(negedge clk) begin
    out_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {Stall, Flush, ExCtrl, ExBranch, ExJump, ExRs, ExRt, ExRd,
           MemCtrl, MemWriteReg, WbCtrl, WbWriteReg};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t actual=%h required=%h", $time, a, e);
        $display("  st/fl %b%b/%b%b ex %h/%h mem %h %0d/%0d wb %h %0d/%0d",
                 a.stall, a.flush, e.stall, e.flush, a.exctrl, e.exctrl,
                 a.memctrl, a.memwr, e.memwr, a.wbctrl, a.wbwr, e.wbwr);
      end
      if (Stall) n_stall++;
      if (Flush) n_flush++;
      if (e.flush && (pipe_ex.rt != 0 || 1'b1) && a.flush && !a.stall
          && e.exctrl[3]) n_both++;
    end
  end

  initial begin
    logic st;
    logic [7:0] c;
    int sel;
    pipe_ex = '0; pipe_mem = '0; pipe_wb = '0;
    rst = 1'b1; IdValid = 1'b1; IdCtrl = C_ADDU;
    IdBranch = 1'b0; IdJump = 1'b0;
    IdRs = 5'd1; IdRt = 5'd2; IdRd = 5'd3; ExZero = 1'b0;
    @(posedge clk);
    repeat (2) cycle(1, C_ADDU, 0, 0, 1, 2, 3, 0, 1, st);
    repeat (4) cycle(1, C_ADDU, 0, 0, 1, 2, 3, 0, 0, st);

    issue(1, C_LW,   0, 0, 5'd1, 5'd8, 5'd0, 0);
    issue(1, C_ADDU, 0, 0, 5'd8, 5'd2, 5'd4, 0);
    nop(0);
    issue(1, C_LW,    0, 0, 5'd1, 5'd8, 5'd0, 0);
    issue(1, C_ADDIU, 0, 0, 5'd9, 5'd8, 5'd0, 0);
    issue(1, C_LW,    0, 0, 5'd1, 5'd0, 5'd0, 0);
    issue(1, C_ADDU,  0, 0, 5'd0, 5'd0, 5'd5, 0);

    issue(1, C_BEQ, 1, 0, 5'd2, 5'd3, 5'd0, 0);
    issue(1, C_ADDU, 0, 0, 5'd4, 5'd5, 5'd6, 1);
    nop(0);
    issue(1, C_BEQ, 1, 0, 5'd2, 5'd3, 5'd0, 0);
    issue(1, C_ADDU, 0, 0, 5'd4, 5'd5, 5'd6, 0);

    issue(1, 8'h00, 1, 1, 5'd0, 5'd0, 5'd0, 0);
    issue(1, C_ADDU, 0, 0, 5'd8, 5'd2, 5'd3, 0);
    // Jump-and-load word so a load-use match coincides with a redirect
    issue(1, 8'b00001011, 1, 1, 5'd1, 5'd8, 5'd0, 0);
    issue(1, C_ADDU, 0, 0, 5'd8, 5'd2, 5'd3, 0);
    nop(0);

    issue(1, C_SW | 8'b10000001, 0, 0, 5'd3, 5'd7, 5'd9, 0);
    issue(1, C_SW, 0, 0, 5'd3, 5'd7, 5'd9, 0);
    repeat (3) nop(0);

    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: c = C_LW;
        2, 3: c = C_ADDU;
        4:    c = C_ADDIU;
        5:    c = C_SW | ($urandom_range(0, 1) ? 8'h81 : 8'h00);
        6:    c = C_BEQ;
        default: c = 8'($urandom);
      endcase
      if (n % 97 == 50) begin
        cycle(1, c, 0, 0, 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              1'($urandom), 1, st);
      end else begin
        issue(1'($urandom_range(0, 7) != 0), c,
              sel == 6 || (sel > 6 && $urandom_range(0, 3) == 0),
              $urandom_range(0, 5) == 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 1'($urandom));
      end
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    n_chk++;
    if (n_stall == 0) begin
      n_fail++;
      $display("FAIL stall_seen count=%0d required>0", n_stall);
    end
    n_chk++;
    if (n_flush == 0) begin
      n_fail++;
      $display("FAIL flush_seen count=%0d required>0", n_flush);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
